// File: rtl/drain_pkg.sv
// Shared state encoding and baud-divisor helper for the FIFO-to-UART drain.
package drain_pkg;

  typedef enum logic [2:0] {IDLE, REQ, GAP, LOAD, TX} drain_state_t;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serialiser; a start in the same cycle as done chains the next
// frame directly after the stop bit.
module uart_tx_byte #(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  logic            active_reg;
  logic [8:0]      shift_reg;
  logic [3:0]      bit_idx_reg;
  logic [CW-1:0]   baud_cnt_reg;
  logic            tx_reg;

  assign tx   = tx_reg;
  assign done = active_reg && (baud_cnt_reg == '0) && (bit_idx_reg == 4'd9);

  // bit_idx 0 is the start bit, 1..8 data, 9 the stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg   <= 1'b0;
      shift_reg    <= '1;
      bit_idx_reg  <= '0;
      baud_cnt_reg <= '0;
      tx_reg       <= 1'b1;
    end else if (start) begin
      active_reg   <= 1'b1;
      tx_reg       <= 1'b0;
      shift_reg    <= {1'b1, data};
      bit_idx_reg  <= '0;
      baud_cnt_reg <= BAUD_LAST;
    end else if (active_reg) begin
      if (baud_cnt_reg != '0) begin
        baud_cnt_reg <= baud_cnt_reg - 1'b1;
      end else if (bit_idx_reg == 4'd9) begin
        active_reg <= 1'b0;
      end else begin
        tx_reg       <= shift_reg[0];
        shift_reg    <= {1'b1, shift_reg[8:1]};
        bit_idx_reg  <= bit_idx_reg + 4'd1;
        baud_cnt_reg <= BAUD_LAST;
      end
    end
  end

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops 16-bit words from the pixel FIFO with a held read strobe and sends each
// as two UART bytes, high byte first.
module fifo_uart_drain
  import drain_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int REN_HOLD  = 8,
  parameter int RD_SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fifo_d_available,
  input  logic [15:0] fifo_r_data,
  output logic        fifo_r_en,
  output logic        uart_tx,
  output logic        busy,
  output logic [15:0] words_sent
);

  localparam int DIV     = baud_div(CLK_HZ, BAUD);
  localparam int GAP_LEN = REN_HOLD + RD_SETTLE;
  localparam int HW      = $clog2(GAP_LEN + 1);
  localparam logic [HW-1:0] REQ_LAST = HW'(REN_HOLD - 1);
  localparam logic [HW-1:0] GAP_LAST = HW'(GAP_LEN - 1);

  drain_state_t  state_reg, state_next;
  logic [HW-1:0] cnt_reg, cnt_next;
  logic          byte_sel_reg, byte_sel_next;
  logic [7:0]    low_byte_reg, low_byte_next;
  logic [15:0]   words_reg, words_next;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_done;

  assign fifo_r_en  = (state_reg == REQ);
  assign busy       = (state_reg != IDLE);
  assign words_sent = words_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      byte_sel_reg <= 1'b0;
      low_byte_reg <= '0;
      words_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      byte_sel_reg <= byte_sel_next;
      low_byte_reg <= low_byte_next;
      words_reg    <= words_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    byte_sel_next = byte_sel_reg;
    low_byte_next = low_byte_reg;
    words_next    = words_reg;
    tx_start      = 1'b0;
    tx_data       = 8'h00;
    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (en && fifo_d_available) state_next = REQ;
      end
      REQ: begin
        if (cnt_reg == REQ_LAST) begin
          cnt_next   = '0;
          state_next = GAP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          state_next = LOAD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      // The high byte goes straight from the FIFO bus so its start bit
      // appears the cycle after LOAD; only the low byte needs holding.
      LOAD: begin
        tx_start      = 1'b1;
        tx_data       = fifo_r_data[15:8];
        low_byte_next = fifo_r_data[7:0];
        byte_sel_next = 1'b0;
        state_next    = TX;
      end
      TX: begin
        if (tx_done) begin
          if (!byte_sel_reg) begin
            tx_start      = 1'b1;
            tx_data       = low_byte_reg;
            byte_sel_next = 1'b1;
          end else begin
            words_next = words_reg + 16'd1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  uart_tx_byte #(.DIV(DIV)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (tx_start),
    .data  (tx_data),
    .tx    (uart_tx),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: a queue-based FIFO model feeds the DUT and a
// cycle-exact UART receiver rebuilds the byte stream.
module tb_fifo_uart_drain;

  localparam int DIV       = 10;
  localparam int REN_HOLD  = 8;
  localparam int RD_SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        fifo_d_available = 1'b0;
  logic [15:0] fifo_r_data = 16'h0000;
  logic        fifo_r_en;
  logic        uart_tx;
  logic        busy;
  logic [15:0] words_sent;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [15:0] fifo_q[$];
  logic        force_avail = 1'b0;
  logic [7:0]  rx_q[$];
  int          exp_words = 0;

  // FIFO model / strobe monitor state
  logic        ren_prev = 1'b0;
  int          ren_len = 0;
  int          ren_rises = 0;
  int          ren_bad = 0;
  int          last_high = 0;
  int          last_fall = -1;
  int          min_gap = 1 << 30;
  int          rise_cyc = 0;
  int          settle = 0;
  logic [15:0] pending = 16'h0000;

  // UART receiver state
  logic        mon_active = 1'b0;
  int          mon_bit = 0;
  int          mon_cyc = 0;
  logic        mon_cur = 1'b1;
  logic [7:0]  mon_byte = 8'h00;
  int          frame_err = 0;
  int          tx_low_cnt = 0;
  int          busy_cnt = 0;
  logic        want_lat = 1'b0;
  int          lat = -1;

  fifo_uart_drain #(
    .CLK_HZ    (1000),
    .BAUD      (100),
    .REN_HOLD  (REN_HOLD),
    .RD_SETTLE (RD_SETTLE)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .fifo_d_available (fifo_d_available),
    .fifo_r_data      (fifo_r_data),
    .fifo_r_en        (fifo_r_en),
    .uart_tx          (uart_tx),
    .busy             (busy),
    .words_sent       (words_sent)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // FIFO model: pops on the r_en rising edge, shows junk until RD_SETTLE
  // cycles after r_en falls.
  initial forever begin
    @(negedge clk);
    if (fifo_r_en && !ren_prev) begin
      ren_rises++;
      ren_len = 0;
      rise_cyc = cyc;
      want_lat = 1'b1;
      if (last_fall >= 0 && (cyc - last_fall) < min_gap) min_gap = cyc - last_fall;
      pending = (fifo_q.size() != 0) ? fifo_q.pop_front() : 16'hDEAD;
      fifo_r_data = 16'($urandom);
      settle = 0;
    end
    if (fifo_r_en) ren_len++;
    if (!fifo_r_en && ren_prev) begin
      last_high = ren_len;
      if (ren_len != REN_HOLD) ren_bad++;
      last_fall = cyc;
      settle = RD_SETTLE;
    end else if (settle > 0) begin
      settle--;
      if (settle == 0) fifo_r_data = pending;
    end
    ren_prev = fifo_r_en;
    fifo_d_available = (fifo_q.size() != 0) || force_avail;
  end

  // UART receiver: every cycle of every bit must hold the same level.
  initial forever begin
    @(negedge clk);
    if (!uart_tx) tx_low_cnt++;
    if (busy) busy_cnt++;
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx == 1'b0) begin
        mon_active = 1'b1;
        mon_bit = 0;
        mon_cyc = 1;
        mon_cur = 1'b0;
        if (want_lat) begin
          lat = cyc - rise_cyc;
          want_lat = 1'b0;
        end
      end
    end else begin
      if (mon_cyc == 0) begin
        mon_cur = uart_tx;
        if (mon_bit >= 1 && mon_bit <= 8) mon_byte[mon_bit-1] = uart_tx;
        if (mon_bit == 9 && uart_tx !== 1'b1) frame_err++;
      end else if (uart_tx !== mon_cur) begin
        frame_err++;
      end
      mon_cyc++;
      if (mon_cyc == DIV) begin
        mon_cyc = 0;
        mon_bit++;
        if (mon_bit == 10) begin
          rx_q.push_back(mon_byte);
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    force_avail = 1'b1;
    en = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b need 1", uart_tx); end
    tests++; if (fifo_r_en !== 1'b0) begin fails++; $display("FAIL reset_ren: got %b need 0", fifo_r_en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b need 0", busy); end
    tests++; if (words_sent !== 16'd0) begin fails++; $display("FAIL reset_words: got %0d need 0", words_sent); end
    rst = 1'b0;
    force_avail = 1'b0;
    exp_words = 0;
    repeat (5) @(negedge clk);
    tests++; if (ren_rises != 0) begin fails++; $display("FAIL reset_no_read: got %0d reads need 0", ren_rises); end
    $display("[TB] reset done");
  endtask

  task automatic test_single_word();
    logic [7:0] exp[$];
    int r0, n, fe0;
    rx_q.delete();
    r0 = ren_rises; fe0 = frame_err;
    fifo_q.push_back(16'hA55A);
    exp.push_back(8'hA5); exp.push_back(8'h5A);
    exp_words++;
    en = 1'b1;
    n = 0;
    while (words_sent !== 16'(exp_words) && n < 1000) begin @(negedge clk); n++; end
    tests++; if (words_sent !== 16'(exp_words)) begin fails++; $display("FAIL single_words: got %0d need %0d", words_sent, exp_words); end
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: busy got %b need 0", busy); end
    tests++; if (last_high != REN_HOLD) begin fails++; $display("FAIL single_ren_len: got %0d need %0d", last_high, REN_HOLD); end
    tests++; if (ren_rises - r0 != 1) begin fails++; $display("FAIL single_reads: got %0d need 1", ren_rises - r0); end
    tests++; if (lat != REN_HOLD + REN_HOLD + RD_SETTLE + 1) begin fails++; $display("FAIL single_latency: got %0d need %0d", lat, REN_HOLD + REN_HOLD + RD_SETTLE + 1); end
    tests++; if (frame_err != fe0) begin fails++; $display("FAIL single_framing: got %0d errors need 0", frame_err - fe0); end
    tests++;
    if (rx_q.size() != exp.size()) begin fails++; $display("FAIL single_nbytes: got %0d need %0d", rx_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      tests++; if (rx_q[i] !== exp[i]) begin fails++; $display("FAIL single_byte%0d: got %02h need %02h", i, rx_q[i], exp[i]); end
    end
    en = 1'b0;
    $display("[TB] single word A55A: %0d bytes received", rx_q.size());
  endtask

  task automatic test_empty();
    int r0, l0, b0;
    r0 = ren_rises; l0 = tx_low_cnt; b0 = busy_cnt;
    en = 1'b1;
    repeat (500) @(negedge clk);
    tests++; if (ren_rises != r0) begin fails++; $display("FAIL empty_reads: got %0d need 0", ren_rises - r0); end
    tests++; if (tx_low_cnt != l0) begin fails++; $display("FAIL empty_tx_low: got %0d low cycles need 0", tx_low_cnt - l0); end
    tests++; if (busy_cnt != b0) begin fails++; $display("FAIL empty_busy: got %0d busy cycles need 0", busy_cnt - b0); end
    en = 1'b0;
    $display("[TB] empty fifo: 500 cycles idle");
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[3];
    logic [7:0] exp[$];
    int n, rb0, fe0;
    w[0] = 16'h0102; w[1] = 16'h0304; w[2] = 16'h0506;
    rx_q.delete();
    rb0 = ren_bad; fe0 = frame_err;
    min_gap = 1 << 30; last_fall = -1;
    foreach (w[i]) begin
      fifo_q.push_back(w[i]);
      exp.push_back(w[i][15:8]); exp.push_back(w[i][7:0]);
      exp_words++;
    end
    en = 1'b1;
    n = 0;
    while (words_sent !== 16'(exp_words) && n < 3000) begin @(negedge clk); n++; end
    tests++; if (words_sent !== 16'(exp_words)) begin fails++; $display("FAIL b2b_words: got %0d need %0d", words_sent, exp_words); end
    repeat (3) @(negedge clk);
    tests++; if (min_gap < REN_HOLD + RD_SETTLE + 20 * DIV) begin fails++; $display("FAIL b2b_ren_gap: got %0d need >= %0d", min_gap, REN_HOLD + RD_SETTLE + 20 * DIV); end
    tests++; if (ren_bad != rb0) begin fails++; $display("FAIL b2b_ren_len: got %0d bad pulses need 0", ren_bad - rb0); end
    tests++; if (frame_err != fe0) begin fails++; $display("FAIL b2b_framing: got %0d errors need 0", frame_err - fe0); end
    tests++;
    if (rx_q.size() != exp.size()) begin fails++; $display("FAIL b2b_nbytes: got %0d need %0d", rx_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      tests++; if (rx_q[i] !== exp[i]) begin fails++; $display("FAIL b2b_byte%0d: got %02h need %02h", i, rx_q[i], exp[i]); end
    end
    en = 1'b0;
    $display("[TB] back-to-back: %0d bytes, min r_en gap %0d", rx_q.size(), min_gap);
  endtask

  task automatic test_en_drop();
    logic [7:0] exp[$];
    int n, r0;
    rx_q.delete();
    r0 = ren_rises;
    fifo_q.push_back(16'hBEEF);
    fifo_q.push_back(16'($urandom));
    exp.push_back(8'hBE); exp.push_back(8'hEF);
    exp_words++;
    en = 1'b1;
    n = 0;
    while (uart_tx !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    tests++; if (uart_tx !== 1'b0) begin fails++; $display("FAIL endrop_start: tx got %b need 0", uart_tx); end
    repeat (15) @(negedge clk);
    en = 1'b0;
    n = 0;
    while (words_sent !== 16'(exp_words) && n < 1000) begin @(negedge clk); n++; end
    tests++; if (words_sent !== 16'(exp_words)) begin fails++; $display("FAIL endrop_words: got %0d need %0d", words_sent, exp_words); end
    repeat (300) @(negedge clk);
    tests++; if (fifo_q.size() != 1) begin fails++; $display("FAIL endrop_queue: got %0d left need 1", fifo_q.size()); end
    tests++; if (ren_rises - r0 != 1) begin fails++; $display("FAIL endrop_reads: got %0d need 1", ren_rises - r0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL endrop_busy: got %b need 0", busy); end
    tests++;
    if (rx_q.size() != exp.size()) begin fails++; $display("FAIL endrop_nbytes: got %0d need %0d", rx_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      tests++; if (rx_q[i] !== exp[i]) begin fails++; $display("FAIL endrop_byte%0d: got %02h need %02h", i, rx_q[i], exp[i]); end
    end
    $display("[TB] en drop during BEEF: %0d bytes", rx_q.size());
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w2;
    logic [7:0] exp[$];
    int n, fe0;
    w2 = 16'($urandom);
    fifo_q.push_back(w2);
    rx_q.delete();
    en = 1'b1;
    n = 0;
    while (rx_q.size() < 1 && n < 1000) begin @(negedge clk); n++; end
    tests++; if (rx_q.size() < 1) begin fails++; $display("FAIL midrst_first_byte: got %0d bytes need 1", rx_q.size()); end
    repeat (35) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_busy_before: got %b need 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL midrst_tx: got %b need 1", uart_tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b need 0", busy); end
    tests++; if (words_sent !== 16'd0) begin fails++; $display("FAIL midrst_words: got %0d need 0", words_sent); end
    rst = 1'b0;
    exp_words = 1;
    rx_q.delete();
    fe0 = frame_err;
    exp.push_back(w2[15:8]); exp.push_back(w2[7:0]);
    n = 0;
    while (words_sent !== 16'(exp_words) && n < 1000) begin @(negedge clk); n++; end
    tests++; if (words_sent !== 16'(exp_words)) begin fails++; $display("FAIL midrst_after_words: got %0d need %0d", words_sent, exp_words); end
    repeat (3) @(negedge clk);
    tests++; if (frame_err != fe0) begin fails++; $display("FAIL midrst_framing: got %0d errors need 0", frame_err - fe0); end
    tests++;
    if (rx_q.size() != exp.size()) begin fails++; $display("FAIL midrst_nbytes: got %0d need %0d", rx_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      tests++; if (rx_q[i] !== exp[i]) begin fails++; $display("FAIL midrst_byte%0d: got %02h need %02h", i, rx_q[i], exp[i]); end
    end
    en = 1'b0;
    $display("[TB] reset mid frame, then word %04h", w2);
  endtask

  task automatic test_random();
    logic [7:0] exp[$];
    logic [15:0] w;
    int n, cnt, fe0, rb0;
    rx_q.delete();
    fe0 = frame_err; rb0 = ren_bad;
    cnt = 3 + int'($urandom_range(0, 2));
    for (int i = 0; i < cnt; i++) begin
      w = 16'($urandom);
      fifo_q.push_back(w);
      exp.push_back(w[15:8]); exp.push_back(w[7:0]);
      exp_words++;
    end
    en = 1'b1;
    n = 0;
    while (words_sent !== 16'(exp_words) && n < 5000) begin @(negedge clk); n++; end
    tests++; if (words_sent !== 16'(exp_words)) begin fails++; $display("FAIL rand_words: got %0d need %0d", words_sent, exp_words); end
    repeat (3) @(negedge clk);
    tests++; if (fifo_q.size() != 0) begin fails++; $display("FAIL rand_queue: got %0d left need 0", fifo_q.size()); end
    tests++; if (ren_bad != rb0) begin fails++; $display("FAIL rand_ren_len: got %0d bad pulses need 0", ren_bad - rb0); end
    tests++; if (frame_err != fe0) begin fails++; $display("FAIL rand_framing: got %0d errors need 0", frame_err - fe0); end
    tests++;
    if (rx_q.size() != exp.size()) begin fails++; $display("FAIL rand_nbytes: got %0d need %0d", rx_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      tests++; if (rx_q[i] !== exp[i]) begin fails++; $display("FAIL rand_byte%0d: got %02h need %02h", i, rx_q[i], exp[i]); end
    end
    en = 1'b0;
    $display("[TB] random: %0d words streamed", cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_empty();
    test_back_to_back();
    test_en_drop();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
